pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/hazard_match.sv | 16 +
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage MIPS pipeline control logic.
package pipeline_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Record dst is sized for the widest supported register index; narrower indices zero-extend.
    localparam int unsigned REC_DST_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [REC_DST_W-1:0] dst;
        logic                 reg_write;
        logic                 mem_read;
    } stage_rec_t;

    localparam stage_rec_t  NOP_REC   = '0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
        if (hit_ex) begin
            return FWD_MEM;
        end else if (hit_mem) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source register of the ID instruction against one stage record.
module hazard_match
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] reg_i,
    input  logic                  needed_i,
    input  stage_rec_t            rec_i,
    output logic                  match_o
);

    assign match_o = needed_i && rec_i.valid && rec_i.reg_write && (reg_i != '0) &&
                     (rec_i.dst == REC_DST_W'(reg_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, squash and forwarding control for the MIPS pipeline, driven by shadow
// records of the EX, MEM and WB instructions, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned FORWARDING = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  branch_taken,
    input  logic                  ext_hold,
    output logic                  pc_enable,
    output logic                  if_id_enable,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  flush_events
);

    stage_rec_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d, flush_q, flush_d;

    logic       need_rs, need_rt;
    logic [2:0] hit_rs, hit_rt;
    stage_rec_t stage_rec [3];
    logic       hazard;
    logic       unused_rec;

    assign need_rs = id_valid && id_use_rs && (id_rs != '0);
    assign need_rt = id_valid && id_use_rt && (id_rt != '0);

    assign stage_rec[0] = ex_q;
    assign stage_rec[1] = mem_q;
    assign stage_rec[2] = wb_q;

    for (genvar s = 0; s < 3; s++) begin : g_stage
        hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs (
            .reg_i    (id_rs),
            .needed_i (need_rs),
            .rec_i    (stage_rec[s]),
            .match_o  (hit_rs[s])
        );
        hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rt (
            .reg_i    (id_rt),
            .needed_i (need_rt),
            .rec_i    (stage_rec[s]),
            .match_o  (hit_rt[s])
        );
    end

    // With forwarding only a load in EX cannot be bypassed in time.
    assign hazard = (FORWARDING != 0) ? (ex_q.mem_read && (hit_rs[0] || hit_rt[0]))
                                      : ((|hit_rs) || (|hit_rt));

    assign unused_rec = ^{mem_q.mem_read, wb_q.mem_read, hit_rs[2], hit_rt[2]};

    always_comb begin
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        ex_d         = ex_q;
        mem_d        = mem_q;
        wb_d         = wb_q;
        fwd_a_d      = fwd_a_q;
        fwd_b_d      = fwd_b_q;
        stall_d      = stall_q;
        flush_d      = flush_q;

        if (ext_hold) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            ex_d         = NOP_REC;
            mem_d        = NOP_REC;
            wb_d         = mem_q;
            fwd_a_d      = FWD_RF;
            fwd_b_d      = FWD_RF;
            if (flush_q != '1) flush_d = flush_q + 1'b1;
        end else if (hazard) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_bubble = 1'b1;
            ex_d         = NOP_REC;
            mem_d        = ex_q;
            wb_d         = mem_q;
            fwd_a_d      = FWD_RF;
            fwd_b_d      = FWD_RF;
            if (stall_q != '1) stall_d = stall_q + 1'b1;
        end else begin
            ex_d.valid     = id_valid;
            ex_d.dst       = REC_DST_W'(id_dst);
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            mem_d          = ex_q;
            wb_d           = mem_q;
            if (FORWARDING != 0) begin
                fwd_a_d = fwd_sel(hit_rs[0], hit_rs[1]);
                fwd_b_d = fwd_sel(hit_rt[0], hit_rt[1]);
            end else begin
                fwd_a_d = FWD_RF;
                fwd_b_d = FWD_RF;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q    <= NOP_REC;
            mem_q   <= NOP_REC;
            wb_q    <= NOP_REC;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign fwd_a        = fwd_a_q;
    assign fwd_b        = fwd_b_q;
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule
